// File: rtl/io_led_rgb_scan_gen.sv
// io_led_rgb_scan_gen: multiplexed RGB LED scan / PWM controller on the 16-bit IO bus.
// Holds one 24-bit colour per LED and lights one LED at a time, with CPwmBits PWM per channel.
// Optional dead-time blanking can be inserted between LEDs.
// Build macro IO_LED_RGB_READBACK_EN: COLOR (+4) becomes readable as a D access at colour[ptr].
//
// state    | meaning
// ST_OFF   | scan stopped, pins dark, counters cleared
// ST_LIT   | one LED selected, PWM counter running over its slot
// ST_BLANK | dead time between two LED slots, pins dark
module io_led_rgb_scan_gen #(
  parameter logic [15:0] CAddrBase = 16'h0000,
  parameter int          CLedCnt   = 16,
  parameter int          CPwmBits  = 8,
  parameter int          CBlankCyc = 4
) (
  input  logic               AClkH,
  input  logic               AResetH,
  input  logic               AClkHEn,
  input  logic [15:0]        AIoAddr,
  input  logic [63:0]        AIoMosi,
  input  logic [3:0]         AIoWrSize,
  input  logic [3:0]         AIoRdSize,
  output logic [63:0]        AIoMiso,
  output logic               AIoAddrAck,
  output logic               AIoAddrErr,
  output logic [CLedCnt-1:0] ALedIdx,
  output logic [2:0]         AColor
);

  localparam int                 CPtrW      = (CLedCnt > 1) ? $clog2(CLedCnt) : 1;
  localparam logic [CPtrW-1:0]   CLastIdx   = CPtrW'(CLedCnt - 1);
  localparam logic [CPwmBits-1:0] CCntMax   = '1;
  localparam logic [7:0]         CBlankLoad = 8'(CBlankCyc - 1);

  localparam logic [3:0] CSizeB = 4'b0001;
  localparam logic [3:0] CSizeD = 4'b0100;

  typedef enum logic [1:0] {ST_OFF, ST_LIT, ST_BLANK} state_t;
  typedef logic [2:0][CPwmBits-1:0] shadow_t;

  // Only the top CPwmBits of each colour byte drive the PWM compare.
  function automatic shadow_t to_shadow(input logic [23:0] c);
    shadow_t s;
    s[2] = c[23 -: CPwmBits];
    s[1] = c[15 -: CPwmBits];
    s[0] = c[7 -: CPwmBits];
    return s;
  endfunction

  // register file state
  logic [1:0]       ctrl_q, ctrl_d;
  logic [CPtrW-1:0] ptr_q, ptr_d;
  logic [23:0]      colour_q [CLedCnt];
  logic [23:0]      colour_d [CLedCnt];

  // scan state
  state_t              state_q, state_d;
  logic [CPwmBits-1:0] cnt_q, cnt_d;
  logic [CPtrW-1:0]    idx_q, idx_d, idx_nxt;
  logic [7:0]          bcnt_q, bcnt_d;
  shadow_t             shadow_q, shadow_d;
  logic [CLedCnt-1:0]  led_idx_q, led_idx_d;
  logic [2:0]          color_q, color_d;

  // IO decode
  logic [15:0] off_full;
  logic [2:0]  off;
  logic        in_win, wr_any, rd_any, wr_ok, rd_ok, io_hit, io_legal, wr_en;
  logic        unused_mosi;

  assign off_full = AIoAddr - CAddrBase;
  assign off      = off_full[2:0];
  assign in_win   = (off_full < 16'd8);
  assign wr_any   = |AIoWrSize;
  assign rd_any   = |AIoRdSize;

  assign wr_ok = (((off == 3'd0) || (off == 3'd1)) && (AIoWrSize == CSizeB)) ||
                 ((off == 3'd4) && (AIoWrSize == CSizeD));
`ifdef IO_LED_RGB_READBACK_EN
  assign rd_ok = (((off == 3'd0) || (off == 3'd1)) && (AIoRdSize == CSizeB)) ||
                 ((off == 3'd4) && (AIoRdSize == CSizeD));
`else
  assign rd_ok = ((off == 3'd0) || (off == 3'd1)) && (AIoRdSize == CSizeB);
`endif

  // A combined access is only accepted when every active strobe is legal.
  assign io_hit     = in_win && (wr_any || rd_any);
  assign io_legal   = (!wr_any || wr_ok) && (!rd_any || rd_ok);
  assign AIoAddrAck = io_hit && io_legal;
  assign AIoAddrErr = io_hit && !io_legal;
  assign wr_en      = AIoAddrAck && wr_any;

  assign unused_mosi = ^AIoMosi[63:24];

  // read data mux, zero unless a legal read hits the window
  always_comb begin
    AIoMiso = '0;
    if (AIoAddrAck && rd_any) begin
      if (off == 3'd0) begin
        AIoMiso = 64'(ctrl_q);
      end else if (off == 3'd1) begin
        AIoMiso = 64'(ptr_q);
`ifdef IO_LED_RGB_READBACK_EN
      end else if (off == 3'd4) begin
        AIoMiso = 64'(colour_q[ptr_q]);
`endif
      end
    end
  end

  // register writes: CTRL, IDX pointer, COLOR with pointer auto-increment
  always_comb begin
    ctrl_d   = ctrl_q;
    ptr_d    = ptr_q;
    colour_d = colour_q;
    if (wr_en) begin
      if (off == 3'd0) begin
        ctrl_d = AIoMosi[1:0];
      end else if (off == 3'd1) begin
        if ({8'h00, AIoMosi[7:0]} >= 16'(CLedCnt)) ptr_d = '0;
        else ptr_d = AIoMosi[CPtrW-1:0];
      end else if (off == 3'd4) begin
        colour_d[ptr_q] = AIoMosi[23:0];
        ptr_d = (ptr_q == CLastIdx) ? '0 : ptr_q + CPtrW'(1);
      end
    end
  end

  // register file flops; a dropped clock enable also drops the write
  always_ff @(posedge AClkH) begin
    if (AResetH) begin
      ctrl_q   <= '0;
      ptr_q    <= '0;
      colour_q <= '{default: '0};
    end else if (AClkHEn) begin
      ctrl_q   <= ctrl_d;
      ptr_q    <= ptr_d;
      colour_q <= colour_d;
    end
  end

  assign idx_nxt = (idx_q == CLastIdx) ? '0 : idx_q + CPtrW'(1);

  // scan FSM next state and pin values; pins follow the current state one cycle later
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    bcnt_d    = bcnt_q;
    shadow_d  = shadow_q;
    led_idx_d = '0;
    color_d   = '0;

    if (ctrl_q[0] && (state_q == ST_LIT)) begin
      led_idx_d = CLedCnt'(1) << idx_q;
      color_d   = {cnt_q < shadow_q[2], cnt_q < shadow_q[1], cnt_q < shadow_q[0]};
    end

    if (!ctrl_q[0]) begin
      state_d = ST_OFF;
      cnt_d   = '0;
      idx_d   = '0;
      bcnt_d  = '0;
    end else begin
      case (state_q)
        ST_OFF: begin
          state_d  = ST_LIT;
          cnt_d    = '0;
          idx_d    = '0;
          shadow_d = to_shadow(colour_q[0]);
        end
        ST_LIT: begin
          if (cnt_q == CCntMax) begin
            cnt_d = '0;
            idx_d = idx_nxt;
            if (ctrl_q[1]) begin
              state_d = ST_BLANK;
              bcnt_d  = CBlankLoad;
            end else begin
              shadow_d = to_shadow(colour_q[idx_nxt]);
            end
          end else begin
            cnt_d = cnt_q + CPwmBits'(1);
          end
        end
        ST_BLANK: begin
          if (bcnt_q == 8'd0) begin
            state_d  = ST_LIT;
            shadow_d = to_shadow(colour_q[idx_q]);
          end else begin
            bcnt_d = bcnt_q - 8'd1;
          end
        end
        default: state_d = ST_OFF;
      endcase
    end
  end

  // scan flops and registered pins
  always_ff @(posedge AClkH) begin
    if (AResetH) begin
      state_q   <= ST_OFF;
      cnt_q     <= '0;
      idx_q     <= '0;
      bcnt_q    <= '0;
      shadow_q  <= '0;
      led_idx_q <= '0;
      color_q   <= '0;
    end else if (AClkHEn) begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      bcnt_q    <= bcnt_d;
      shadow_q  <= shadow_d;
      led_idx_q <= led_idx_d;
      color_q   <= color_d;
    end
  end

  assign ALedIdx = led_idx_q;
  assign AColor  = color_q;

endmodule

// File: tb/tb_io_led_rgb_scan_gen.sv
// Bench for io_led_rgb_scan_gen: slot-position model checked every cycle plus directed literal checks.
module tb_io_led_rgb_scan_gen;
  localparam int N   = 16;
  localparam int PER = 256;
  localparam int BLK = 4;
  localparam logic [3:0] SZ_B = 4'b0001;
  localparam logic [3:0] SZ_W = 4'b0010;
  localparam logic [3:0] SZ_D = 4'b0100;
  localparam logic [3:0] SZ_Q = 4'b1000;

  logic        clk = 1'b0;
  logic        rst, clk_en;
  logic [15:0] addr;
  logic [63:0] mosi, miso;
  logic [3:0]  wr_size, rd_size;
  logic        ack, err;
  logic [15:0] led_idx;
  logic [2:0]  color;

  always #5 clk = ~clk;

  io_led_rgb_scan_gen #(
    .CAddrBase(16'h0000), .CLedCnt(N), .CPwmBits(8), .CBlankCyc(BLK)
  ) dut (
    .AClkH(clk), .AResetH(rst), .AClkHEn(clk_en),
    .AIoAddr(addr), .AIoMosi(mosi), .AIoWrSize(wr_size), .AIoRdSize(rd_size),
    .AIoMiso(miso), .AIoAddrAck(ack), .AIoAddrErr(err),
    .ALedIdx(led_idx), .AColor(color)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A running scan is described by the lit LED and the position inside its slot:
  // positions 0..PER-1 are lit, PER..PER+BLK-1 are dead time (only when blanking was on).
  int m_en, m_blank, m_ptr, m_run, m_led, m_pos;
  int m_col [N];
  int m_sh  [3];
  logic [15:0] exp_led = '0;
  logic [2:0]  exp_col = '0;
  bit chk_on = 1'b0;

  task automatic load_sh(input int led);
    m_sh[0] = (m_col[led] >> 16) & 255;
    m_sh[1] = (m_col[led] >> 8) & 255;
    m_sh[2] = m_col[led] & 255;
  endtask

  task automatic model_step();
    int off;
    if (rst) begin
      m_en = 0; m_blank = 0; m_ptr = 0; m_run = 0; m_led = 0; m_pos = 0;
      for (int i = 0; i < N; i++) m_col[i] = 0;
      for (int i = 0; i < 3; i++) m_sh[i] = 0;
      exp_led = '0;
      exp_col = '0;
    end else if (clk_en) begin
      if (m_en != 0 && m_run != 0 && m_pos < PER) begin
        exp_led = 16'd1 << m_led;
        exp_col = {m_pos < m_sh[0], m_pos < m_sh[1], m_pos < m_sh[2]};
      end else begin
        exp_led = '0;
        exp_col = '0;
      end
      if (m_en == 0) begin
        m_run = 0;
      end else if (m_run == 0) begin
        m_run = 1; m_led = 0; m_pos = 0; load_sh(0);
      end else begin
        m_pos++;
        if (m_pos == PER) begin
          m_led = (m_led + 1) % N;
          if (m_blank == 0) begin m_pos = 0; load_sh(m_led); end
        end else if (m_pos == PER + BLK) begin
          m_pos = 0; load_sh(m_led);
        end
      end
      off = int'(addr);
      if (rd_size == 4'b0000) begin
        if (wr_size == SZ_B && off == 0) begin
          m_en = int'(mosi[0]); m_blank = int'(mosi[1]);
        end else if (wr_size == SZ_B && off == 1) begin
          m_ptr = (int'(mosi[7:0]) >= N) ? 0 : int'(mosi[7:0]);
        end else if (wr_size == SZ_D && off == 4) begin
          m_col[m_ptr] = int'(mosi[23:0]);
          m_ptr = (m_ptr + 1) % N;
        end
      end
    end
  endtask

  always @(posedge clk) model_step();

  // compare pins against the model on every cycle once out of the first reset
  always @(negedge clk) begin
    if (chk_on) begin
      check("pins_led", 64'(led_idx), 64'(exp_led));
      check("pins_color", 64'(color), 64'(exp_col));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic io_wr(input logic [15:0] a, input logic [63:0] d, input logic [3:0] sz,
                       output logic a_ack, output logic a_err);
    addr = a; mosi = d; wr_size = sz;
    #1;
    a_ack = ack; a_err = err;
    @(posedge clk); #1;
    wr_size = '0; mosi = '0;
  endtask

  task automatic io_rd(input logic [15:0] a, input logic [3:0] sz,
                       output logic [63:0] d, output logic a_ack, output logic a_err);
    addr = a; rd_size = sz;
    #1;
    d = miso; a_ack = ack; a_err = err;
    @(posedge clk); #1;
    rd_size = '0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_led(input logic [15:0] tgt, input string nm);
    bit found = 1'b0;
    for (int k = 0; k < 6000; k++) begin
      @(negedge clk);
      if (led_idx == tgt) begin found = 1'b1; break; end
    end
    check(nm, 64'(found), 64'd1);
  endtask

  task automatic measure_slot(input logic [15:0] tgt, output int len, output int r,
                              output int g, output int b, output logic [15:0] nxt);
    wait_led(tgt, "wait_slot");
    len = 0; r = 0; g = 0; b = 0;
    while (led_idx == tgt && len < 2000) begin
      len++;
      if (color[2]) r++;
      if (color[1]) g++;
      if (color[0]) b++;
      @(negedge clk);
    end
    nxt = led_idx;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [63:0] rd;
    logic        a, e;
    logic [15:0] nxt;
    int len, r, g, b, gap;

    rst = 1'b1; clk_en = 1'b1; addr = '0; mosi = '0; wr_size = '0; rd_size = '0;
    cyc(3);
    rst = 1'b0;
    chk_on = 1'b1;

    // reset state
    check("rst_led", 64'(led_idx), 64'd0);
    check("rst_color", 64'(color), 64'd0);
    io_rd(16'd0, SZ_B, rd, a, e);
    check("rst_ctrl", rd, 64'd0);
    check("rst_ctrl_ack", 64'({a, e}), 64'b10);
    io_rd(16'd1, SZ_B, rd, a, e);
    check("rst_idx", rd, 64'd0);

    // enable with no colours: 256-cycle slots, all channels dark
    io_wr(16'd0, 64'h01, SZ_B, a, e);
    check("ctrl_wr_ack", 64'({a, e}), 64'b10);
    measure_slot(16'h0001, len, r, g, b, nxt);
    check("slot0_len", 64'(len), 64'd256);
    check("slot0_rgb", 64'(r + g + b), 64'd0);
    check("slot0_next", 64'(nxt), 64'h0002);
    cyc(4200);
    io_wr(16'd0, 64'h00, SZ_B, a, e);
    cyc(1);
    check("off_led", 64'(led_idx), 64'd0);

    // IDX=3, COLOR=0x00FF8001 -> LED3 duty 255/128/1
    io_wr(16'd1, 64'd3, SZ_B, a, e);
    io_wr(16'd4, 64'h00FF8001, SZ_D, a, e);
    check("color_wr_ack", 64'({a, e}), 64'b10);
    io_rd(16'd1, SZ_B, rd, a, e);
    check("idx_after_color", rd, 64'd4);
    io_wr(16'd0, 64'h01, SZ_B, a, e);
    measure_slot(16'h0008, len, r, g, b, nxt);
    check("led3_len", 64'(len), 64'd256);
    check("led3_r", 64'(r), 64'd255);
    check("led3_g", 64'(g), 64'd128);
    check("led3_b", 64'(b), 64'd1);
    io_wr(16'd0, 64'h00, SZ_B, a, e);

    // pointer wrap 15 -> 0, out-of-range IDX write
    io_wr(16'd1, 64'd15, SZ_B, a, e);
    io_wr(16'd4, 64'h00112233, SZ_D, a, e);
    io_wr(16'd4, 64'h00445566, SZ_D, a, e);
    io_rd(16'd1, SZ_B, rd, a, e);
    check("idx_wrap", rd, 64'd1);
    io_wr(16'd1, 64'd40, SZ_B, a, e);
    io_rd(16'd1, SZ_B, rd, a, e);
    check("idx_oob", rd, 64'd0);
    io_wr(16'd0, 64'h01, SZ_B, a, e);
    measure_slot(16'h0001, len, r, g, b, nxt);
    check("led0_r", 64'(r), 64'd68);
    check("led0_g", 64'(g), 64'd85);
    check("led0_b", 64'(b), 64'd102);
    measure_slot(16'h8000, len, r, g, b, nxt);
    check("led15_rgb", 64'({r[7:0], g[7:0], b[7:0]}), 64'h112233);
    check("led15_next", 64'(nxt), 64'h0001);

    // blanking on (upper CTRL bits ignored)
    io_wr(16'd0, 64'hFF, SZ_B, a, e);
    io_rd(16'd0, SZ_B, rd, a, e);
    check("ctrl_rd", rd, 64'd3);
    measure_slot(16'h0002, len, r, g, b, nxt);
    check("blank_slot_len", 64'(len), 64'd256);
    gap = 0;
    while (led_idx == 16'h0000 && gap < 100) begin
      gap++;
      @(negedge clk);
    end
    check("blank_gap", 64'(gap), 64'd4);
    check("after_gap", 64'(led_idx), 64'h0004);

    // colour write to the lit LED2 mid-slot: old colour (0) persists for this slot
    repeat (100) @(negedge clk);
    io_wr(16'd1, 64'd2, SZ_B, a, e);
    io_wr(16'd4, 64'h00FFFFFF, SZ_D, a, e);
    r = 0;
    for (int k = 0; k < 300 && led_idx == 16'h0004; k++) begin
      if (color != 3'b000) r++;
      @(negedge clk);
    end
    check("midslot_hold", 64'(r), 64'd0);
    measure_slot(16'h0004, len, r, g, b, nxt);
    check("led2_full_r", 64'(r), 64'd255);
    check("led2_full_b", 64'(b), 64'd255);

    // CTRL=0 mid-scan -> pins dark on the next cycle
    wait_led(16'h0010, "wait_led4");
    repeat (20) @(negedge clk);
    io_wr(16'd0, 64'h00, SZ_B, a, e);
    cyc(1);
    check("ctrl0_led", 64'(led_idx), 64'd0);
    check("ctrl0_color", 64'(color), 64'd0);

    // illegal accesses
    io_wr(16'd4, 64'h123456, SZ_W, a, e);
    check("w_wr_col", 64'({a, e}), 64'b01);
    io_rd(16'd6, SZ_B, rd, a, e);
    check("rd_off6", 64'({a, e}), 64'b01);
    check("rd_off6_miso", rd, 64'd0);
    io_wr(16'd2, 64'h01, SZ_B, a, e);
    check("wr_off2", 64'({a, e}), 64'b01);
    io_wr(16'd0, 64'h01, SZ_Q, a, e);
    check("q_wr_ctrl", 64'({a, e}), 64'b01);
    io_rd(16'd0, SZ_B, rd, a, e);
    check("ctrl_unchanged", rd, 64'd0);
    io_rd(16'd1, SZ_B, rd, a, e);
    check("idx_unchanged", rd, 64'd3);
    io_rd(16'd8, SZ_B, rd, a, e);
    check("outside_win", 64'({a, e}), 64'b00);
    io_rd(16'd4, SZ_D, rd, a, e);
`ifdef IO_LED_RGB_READBACK_EN
    check("color_rb_ack", 64'({a, e}), 64'b10);
    check("color_rb", rd, 64'h00FF8001);
    io_rd(16'd1, SZ_B, rd, a, e);
    check("color_rb_ptr", rd, 64'd3);
`else
    check("color_rd_err", 64'({a, e}), 64'b01);
    check("color_rd_miso", rd, 64'd0);
`endif

    // clock enable low: pins hold, write dropped
    io_wr(16'd0, 64'h01, SZ_B, a, e);
    cyc(300);
    clk_en = 1'b0;
    cyc(50);
    io_wr(16'd1, 64'd7, SZ_B, a, e);
    clk_en = 1'b1;
    io_rd(16'd1, SZ_B, rd, a, e);
    check("clken_drop", rd, 64'd3);
    cyc(100);

    // reset mid-scan with clock enable low
    clk_en = 1'b0;
    rst = 1'b1;
    cyc(1);
    check("rst_mid_led", 64'(led_idx), 64'd0);
    check("rst_mid_color", 64'(color), 64'd0);
    rst = 1'b0;
    io_rd(16'd0, SZ_B, rd, a, e);
    check("rst_mid_ctrl", rd, 64'd0);
    clk_en = 1'b1;
    io_wr(16'd0, 64'h01, SZ_B, a, e);
    measure_slot(16'h0008, len, r, g, b, nxt);
    check("rst_cleared_led3", 64'(r + g + b), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
